// File: rtl/bot_if_pkg.sv
// Shared types and constants for the rojobot-to-SweRVolf update bridge.
package bot_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_TRIP
  } state_t;

  // BotInfo word layout as packed by rojobot.
  localparam int FIELD_W     = 8;
  localparam int LOCX_LSB    = 24;
  localparam int LOCY_LSB    = 16;
  localparam int SENSORS_LSB = 8;
  localparam int INFO_LSB    = 0;

  typedef struct packed {
    logic [FIELD_W-1:0] locx;
    logic [FIELD_W-1:0] locy;
    logic [FIELD_W-1:0] sensors;
    logic [FIELD_W-1:0] info;
  } bot_info_t;

  localparam logic [7:0] DEFAULT_STOP_CMD = 8'h00;

endpackage

// File: rtl/sync_edge_det.sv
// Optional N-flop synchroniser followed by a registered rising-edge pulse.
// STAGES=0 skips synchronisation for inputs already in the clk domain.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic level;
  logic prev;

  generate
    if (STAGES == 0) begin : g_direct
      assign level = din;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;

      // NOTE: reset is synchronous -- rstn is only looked at on the clock edge,
      // so it must be inside the edge-triggered branch, not in the sensitivity list.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign level = sync_q[STAGES-1];
    end
  endgenerate

  // NOTE: non-blocking assignments let prev and pulse both see the old level
  // sampled in the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/bot_update_ctrl.sv
// Bridges rojobot update strobes into the core clock: snapshots BotInfo, keeps a
// sticky interrupt flag, counts updates/overruns and stops the motors on neglect.
module bot_update_ctrl
  import bot_if_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         WDT_MISSES  = 4,
  parameter logic [7:0] STOP_CMD    = DEFAULT_STOP_CMD,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_upd_sysregs,
  input  logic [31:0]      i_bot_info,
  input  logic             i_int_ack,
  input  logic [7:0]       i_bot_ctrl,
  input  logic             i_ovr_clr,
  output logic [31:0]      o_bot_info,
  output logic             o_bot_upd_sync,
  output logic [7:0]       o_mot_ctl,
  output logic [15:0]      o_upd_cnt,
  output logic [CNT_W-1:0] o_overrun_cnt,
  output logic             o_wdt_trip
);

  localparam int MISS_W = (WDT_MISSES < 2) ? 1 : $clog2(WDT_MISSES + 1);

  logic              upd_evt;
  logic              ack_evt;
  state_t            state, state_next;
  logic [MISS_W-1:0] miss, miss_next;
  logic [CNT_W-1:0]  ovr, ovr_next;
  logic              ovr_inc;
  bot_info_t         snap;
  logic [15:0]       upd_cnt;
  logic [7:0]        mot_ctl;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_upd_det (
    .clk   (clk),
    .rstn  (rstn),
    .din   (i_upd_sysregs),
    .pulse (upd_evt)
  );

  sync_edge_det #(.STAGES(0)) u_ack_det (
    .clk   (clk),
    .rstn  (rstn),
    .din   (i_int_ack),
    .pulse (ack_evt)
  );

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      miss    <= '0;
      ovr     <= '0;
      snap    <= '0;
      upd_cnt <= '0;
      mot_ctl <= STOP_CMD;
    end else begin
      state   <= state_next;
      miss    <= miss_next;
      ovr     <= ovr_next;
      mot_ctl <= (state == S_TRIP) ? STOP_CMD : i_bot_ctrl;
      if (upd_evt) begin
        snap    <= i_bot_info;
        upd_cnt <= upd_cnt + 16'd1;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    miss_next  = miss;
    ovr_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (upd_evt) begin
          state_next = S_PEND;
          miss_next  = '0;
        end
      end
      S_PEND, S_TRIP: begin
        if (upd_evt && ack_evt) begin
          // The ack retires the old event; the new one becomes the pending one.
          state_next = S_PEND;
          miss_next  = '0;
        end else if (ack_evt) begin
          state_next = S_IDLE;
          miss_next  = '0;
        end else if (upd_evt) begin
          ovr_inc = 1'b1;
          if (miss != '1) miss_next = miss + 1'b1;
          if (state == S_PEND && WDT_MISSES != 0 && miss_next >= MISS_W'(WDT_MISSES))
            state_next = S_TRIP;
        end
      end
      default: begin
        state_next = S_IDLE;
        miss_next  = '0;
      end
    endcase

    // A clear that coincides with an overrun keeps that overrun.
    if (i_ovr_clr)                ovr_next = CNT_W'(ovr_inc);
    else if (ovr_inc && ovr != '1) ovr_next = ovr + 1'b1;
    else                          ovr_next = ovr;
  end

  always_comb begin
    o_bot_upd_sync = (state != S_IDLE);
    o_wdt_trip     = (state == S_TRIP);
    o_bot_info     = snap;
    o_upd_cnt      = upd_cnt;
    o_overrun_cnt  = ovr;
    o_mot_ctl      = mot_ctl;
  end

endmodule

// File: tb/tb_bot_update_ctrl.sv
// Self-checking bench for bot_update_ctrl: vector table, scoreboard for snapshots,
// and hand-written sequences for latency, coincident events, held ack and reset.
module tb_bot_update_ctrl;
  import bot_if_pkg::*;

  localparam int         CNT_W = 8;
  localparam int         WDT   = 4;
  localparam logic [7:0] STOP  = 8'h00;
  localparam logic [7:0] CTRL  = 8'h33;

  logic             clk;
  logic             rstn;
  logic             i_upd_sysregs;
  logic [31:0]      i_bot_info;
  logic             i_int_ack;
  logic [7:0]       i_bot_ctrl;
  logic             i_ovr_clr;
  logic [31:0]      o_bot_info;
  logic             o_bot_upd_sync;
  logic [7:0]       o_mot_ctl;
  logic [15:0]      o_upd_cnt;
  logic [CNT_W-1:0] o_overrun_cnt;
  logic             o_wdt_trip;

  bot_update_ctrl #(
    .SYNC_STAGES (2),
    .WDT_MISSES  (WDT),
    .STOP_CMD    (STOP),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_upd_sysregs  (i_upd_sysregs),
    .i_bot_info     (i_bot_info),
    .i_int_ack      (i_int_ack),
    .i_bot_ctrl     (i_bot_ctrl),
    .i_ovr_clr      (i_ovr_clr),
    .o_bot_info     (o_bot_info),
    .o_bot_upd_sync (o_bot_upd_sync),
    .o_mot_ctl      (o_mot_ctl),
    .o_upd_cnt      (o_upd_cnt),
    .o_overrun_cnt  (o_overrun_cnt),
    .o_wdt_trip     (o_wdt_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] info;
    logic [15:0] cnt;
  } upd_exp_t;

  upd_exp_t    sb_q[$];
  logic [15:0] exp_cnt;

  typedef enum {OP_UPD, OP_ACK, OP_CLR} op_t;
  typedef struct {
    op_t         op;
    logic [31:0] info;
    logic        flag;
    logic [7:0]  ovr;
    logic        trip;
    logic [7:0]  mot;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data);
    exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back('{info: data, cnt: exp_cnt});
  endtask

  task automatic pulse_upd(input logic [31:0] data);
    i_bot_info    = data;
    i_upd_sysregs = 1'b1;
    push_exp(data);
    step();
    step();
    i_upd_sysregs = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_ack();
    i_int_ack = 1'b1;
    step();
    i_int_ack = 1'b0;
    repeat (2) step();
  endtask

  task automatic pulse_clr();
    i_ovr_clr = 1'b1;
    step();
    i_ovr_clr = 1'b0;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_info"}, o_bot_info, 32'h0);
    check({tag, "_flag"}, 32'(o_bot_upd_sync), 32'h0);
    check({tag, "_cnt"},  32'(o_upd_cnt), 32'h0);
    check({tag, "_ovr"},  32'(o_overrun_cnt), 32'h0);
    check({tag, "_trip"}, 32'(o_wdt_trip), 32'h0);
    check({tag, "_mot"},  32'(o_mot_ctl), 32'(STOP));
  endtask

  // Scoreboard monitor: every change of o_upd_cnt outside reset retires one entry.
  initial begin : monitor
    logic [15:0] last;
    upd_exp_t    e;
    last = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rstn === 1'b1 && o_upd_cnt !== last) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_update", 32'(o_upd_cnt), 32'(last));
        end else begin
          e = sb_q.pop_front();
          check("sb_info", o_bot_info, e.info);
          check("sb_cnt", 32'(o_upd_cnt), 32'(e.cnt));
        end
      end
      last = o_upd_cnt;
    end
  end

  initial begin
    vecs[0]  = '{OP_UPD, 32'hA0A1A2A3, 1'b1, 8'd0, 1'b0, CTRL};
    vecs[1]  = '{OP_UPD, 32'hB0B1B2B3, 1'b1, 8'd1, 1'b0, CTRL};
    vecs[2]  = '{OP_UPD, 32'hC0C1C2C3, 1'b1, 8'd2, 1'b0, CTRL};
    vecs[3]  = '{OP_ACK, 32'h0,        1'b0, 8'd2, 1'b0, CTRL};
    vecs[4]  = '{OP_CLR, 32'h0,        1'b0, 8'd0, 1'b0, CTRL};
    vecs[5]  = '{OP_UPD, 32'h01020304, 1'b1, 8'd0, 1'b0, CTRL};
    vecs[6]  = '{OP_UPD, 32'h11121314, 1'b1, 8'd1, 1'b0, CTRL};
    vecs[7]  = '{OP_UPD, 32'h21222324, 1'b1, 8'd2, 1'b0, CTRL};
    vecs[8]  = '{OP_UPD, 32'h31323334, 1'b1, 8'd3, 1'b0, CTRL};
    vecs[9]  = '{OP_UPD, 32'h41424344, 1'b1, 8'd4, 1'b1, STOP};
    vecs[10] = '{OP_UPD, 32'h51525354, 1'b1, 8'd5, 1'b1, STOP};
    vecs[11] = '{OP_ACK, 32'h0,        1'b0, 8'd5, 1'b0, CTRL};

    rstn          = 1'b0;
    i_upd_sysregs = 1'b0;
    i_bot_info    = 32'h0;
    i_int_ack     = 1'b0;
    i_bot_ctrl    = CTRL;
    i_ovr_clr     = 1'b0;
    exp_cnt       = '0;

    step();
    step();
    check_reset_outputs("reset");
    rstn = 1'b1;
    step();
    check("post_reset_mot", 32'(o_mot_ctl), 32'(CTRL));

    // First update: the flag must appear at E3, not earlier.
    i_bot_info    = 32'h12345678;
    i_upd_sysregs = 1'b1;
    push_exp(32'h12345678);
    step();
    check("lat_e0_flag", 32'(o_bot_upd_sync), 32'h0);
    step();
    i_upd_sysregs = 1'b0;
    check("lat_e1_flag", 32'(o_bot_upd_sync), 32'h0);
    step();
    check("lat_e2_flag", 32'(o_bot_upd_sync), 32'h0);
    check("lat_e2_info", o_bot_info, 32'h0);
    step();
    check("lat_e3_flag", 32'(o_bot_upd_sync), 32'h1);
    check("lat_e3_info", o_bot_info, 32'h12345678);
    check("lat_e3_cnt", 32'(o_upd_cnt), 32'h1);
    check("field_locx", 32'(o_bot_info[LOCX_LSB +: FIELD_W]), 32'h12);
    check("field_locy", 32'(o_bot_info[LOCY_LSB +: FIELD_W]), 32'h34);
    check("field_sensors", 32'(o_bot_info[SENSORS_LSB +: FIELD_W]), 32'h56);
    check("field_info", 32'(o_bot_info[INFO_LSB +: FIELD_W]), 32'h78);
    pulse_ack();
    check("lat_ack_flag", 32'(o_bot_upd_sync), 32'h0);

    // Overrun counting, clear, watchdog trip and recovery.
    for (int i = 0; i < 12; i++) begin
      case (vecs[i].op)
        OP_UPD:  pulse_upd(vecs[i].info);
        OP_ACK:  pulse_ack();
        default: pulse_clr();
      endcase
      check($sformatf("vec%0d_flag", i), 32'(o_bot_upd_sync), 32'(vecs[i].flag));
      check($sformatf("vec%0d_ovr", i),  32'(o_overrun_cnt), 32'(vecs[i].ovr));
      check($sformatf("vec%0d_trip", i), 32'(o_wdt_trip), 32'(vecs[i].trip));
      check($sformatf("vec%0d_mot", i),  32'(o_mot_ctl), 32'(vecs[i].mot));
    end

    // Coincident update and acknowledge while pending.
    pulse_upd(32'hDEAD0001);
    i_bot_info    = 32'hDEAD0002;
    i_upd_sysregs = 1'b1;
    push_exp(32'hDEAD0002);
    step();
    step();
    i_upd_sysregs = 1'b0;
    i_int_ack     = 1'b1;
    step();
    i_int_ack = 1'b0;
    step();
    check("coinc_flag", 32'(o_bot_upd_sync), 32'h1);
    check("coinc_ovr", 32'(o_overrun_cnt), 32'd5);
    check("coinc_info", o_bot_info, 32'hDEAD0002);
    step();
    check("coinc_flag_hold", 32'(o_bot_upd_sync), 32'h1);
    pulse_upd(32'hDEAD0003);
    check("coinc_next_ovr", 32'(o_overrun_cnt), 32'd6);
    check("coinc_next_trip", 32'(o_wdt_trip), 32'h0);
    pulse_ack();
    check("coinc_cleared", 32'(o_bot_upd_sync), 32'h0);

    // A held acknowledge counts once only.
    pulse_upd(32'hC0DE0001);
    i_int_ack = 1'b1;
    repeat (4) step();
    check("hold_first_cleared", 32'(o_bot_upd_sync), 32'h0);
    pulse_upd(32'hC0DE0002);
    repeat (90) step();
    check("hold_second_set", 32'(o_bot_upd_sync), 32'h1);
    check("hold_ovr", 32'(o_overrun_cnt), 32'd6);
    i_int_ack = 1'b0;
    repeat (3) step();
    check("hold_release_flag", 32'(o_bot_upd_sync), 32'h1);
    pulse_ack();
    check("hold_ack_flag", 32'(o_bot_upd_sync), 32'h0);

    // Reset while tripped with non-zero counters.
    for (int i = 0; i < 5; i++) pulse_upd(32'hF0000000 | 32'(i));
    check("pre_rst_trip", 32'(o_wdt_trip), 32'h1);
    check("pre_rst_ovr", 32'(o_overrun_cnt), 32'd10);
    check("pre_rst_mot", 32'(o_mot_ctl), 32'(STOP));
    rstn = 1'b0;
    step();
    check_reset_outputs("trip_reset");
    exp_cnt = '0;
    step();
    rstn = 1'b1;
    step();
    check("post_trip_rst_mot", 32'(o_mot_ctl), 32'(CTRL));
    pulse_upd(32'h0BADF00D);
    check("post_trip_rst_ovr", 32'(o_overrun_cnt), 32'd0);

    repeat (3) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
